// File: rtl/operand_loader.sv
// Key-sequenced operand loader: one 4-bit switch bank captured as x, then y, for the two-digit adder path.
// Latency: operand register loads DEBOUNCE_CYCLES+2 edges after key_n is first sampled low; range_err/operands_valid align with state.
// Backpressure: none; key presses are single events, sw is ignored except at the press edge, clear wins over press.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-high reset
//   sw[3:0]        operand value from switches
//   key_n          raw active-low pushbutton (asynchronous, bouncy)
//   clear          synchronous clear back to LOAD_X with x=y=0
//   x[3:0], y[3:0] registered operands to the adder
//   state[1:0]     00 LOAD_X, 01 LOAD_Y, 10 SHOW
//   operands_valid high while in SHOW
//   new_pair       one-cycle pulse on entry to SHOW
//   range_err      high in SHOW when x+y > 19 (sum the display cannot render)
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_n,
    input  logic       clear,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [1:0] state,
    output logic       operands_valid,
    output logic       new_pair,
    output logic       range_err
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_X = 2'b00,
        LOAD_Y = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic             sync1;
    logic             key_s;
    logic             deb;
    logic [CNT_W-1:0] cnt;
    logic             deb_prev;
    logic [1:0]       settle;
    logic             armed;
    logic             press;

    state_t           cur;
    state_t           nxt;
    logic [3:0]       x_nxt;
    logic [3:0]       y_nxt;
    logic             pair_nxt;
    logic [4:0]       sum_nxt;

    // Two-flop synchronizer; reset to the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync1 <= key_n;
            key_s <= sync1;
        end
    end

    // Debounce: level follows key_s only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (key_s != deb) begin
            if (cnt == CNT_LAST) begin
                deb <= key_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // The debounced level restarts as "released" after reset even if the key is
    // physically held. Events are therefore armed only once the synchronizer has
    // flushed its reset value and a real released level has been observed, so a
    // key held through reset yields nothing until it is released and pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev <= 1'b1;
            settle   <= 2'b00;
            armed    <= 1'b0;
        end else begin
            deb_prev <= deb;
            settle   <= {settle[0], 1'b1};
            if (settle[1] && key_s && deb) begin
                armed <= 1'b1;
            end
        end
    end

    assign press = ~deb & deb_prev & armed;

    always_comb begin
        nxt      = cur;
        x_nxt    = x;
        y_nxt    = y;
        pair_nxt = 1'b0;
        if (clear) begin
            // A press in the same cycle is dropped.
            nxt   = LOAD_X;
            x_nxt = 4'd0;
            y_nxt = 4'd0;
        end else begin
            case (cur)
                LOAD_X: begin
                    if (press) begin
                        nxt   = LOAD_Y;
                        x_nxt = sw;
                    end
                end
                LOAD_Y: begin
                    if (press) begin
                        nxt      = SHOW;
                        y_nxt    = sw;
                        pair_nxt = 1'b1;
                    end
                end
                SHOW: begin
                    if (press) begin
                        nxt   = LOAD_Y;
                        x_nxt = sw;
                    end
                end
                default: begin
                    // Encoding 11 is unreachable; recover to a clean start.
                    nxt   = LOAD_X;
                    x_nxt = 4'd0;
                    y_nxt = 4'd0;
                end
            endcase
        end
    end

    // Sum of the values about to be registered, so range_err lands with the state.
    assign sum_nxt = {1'b0, x_nxt} + {1'b0, y_nxt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur            <= LOAD_X;
            x              <= 4'd0;
            y              <= 4'd0;
            new_pair       <= 1'b0;
            operands_valid <= 1'b0;
            range_err      <= 1'b0;
        end else begin
            cur            <= nxt;
            x              <= x_nxt;
            y              <= y_nxt;
            new_pair       <= pair_nxt;
            operands_valid <= (nxt == SHOW);
            range_err      <= (nxt == SHOW) && (sum_nxt > 5'd19);
        end
    end

    assign state = cur;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the two-digit adder/display path: replaces direct switch wiring of the adder operands with a key-sequenced loader.
- A single 4-bit switch bank is time-shared. Key presses capture operand x, then operand y, into registers.
- The registered x/y feed four_bit_adder. The 5-bit sum then goes to display_unit.
- The block also flags sums the downstream two-digit display cannot render (sum > 19).

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced key level changes (1 ms at 50 MHz; benches use 4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
sw  input  4  operand value from switches, unsigned 0..15
key_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy
clear  input  1  synchronous clear, active-high
x  output  4  registered operand x to adder
y  output  4  registered operand y to adder
state  output  2  FSM state: 00 LOAD_X, 01 LOAD_Y, 10 SHOW
operands_valid  output  1  high while in SHOW (x and y both loaded)
new_pair  output  1  one-cycle pulse on entry to SHOW
range_err  output  1  high in SHOW when x+y > 19, else 0

Behaviour:
- Reset (async, any time):
  - x=0, y=0, state=LOAD_X, operands_valid=0, new_pair=0, range_err=0.
  - Both sync flops and the debounced level = released (1); debounce counter = 0.
  - A reset mid-debounce discards the pending press.
- Synchronizer: two flops on key_n, both reset to 1. Only the second flop output (key_s) is used downstream.
- Debounce:
  - The counter increments each cycle that key_s differs from the debounced level. It returns to 0 on any cycle they match.
  - When key_s has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes key_s at that edge and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES produce no level change.
  - Release is debounced identically.
- Press event:
  - press = debounced low AND prev_debounced high, where prev_debounced is a registered copy. This gives exactly one cycle per debounced press.
  - Holding the key yields a single event. Release generates no event.
- Latency:
  - Let edge 0 be the first edge sampling key_n low, with key_n then held low.
  - The debounced level flips at edge DEBOUNCE_CYCLES+1.
  - press is high in the following cycle, and the operand register loads at edge DEBOUNCE_CYCLES+2.
  - With DEBOUNCE_CYCLES=4, x/y changes at edge 6.
- sw is sampled only at the edge where press is high. sw changes at other times have no effect.
- FSM, transitions only on press:
  - LOAD_X -> LOAD_Y: x<=sw.
  - LOAD_Y -> SHOW: y<=sw; new_pair high for the next cycle.
  - SHOW -> LOAD_Y: x<=sw; y is held; operands_valid drops the next cycle.
- Encoding 11 is illegal and recovers to LOAD_X on the next edge with x=y=0.
- clear:
  - Next edge: state=LOAD_X, x=0, y=0, new_pair=0.
  - clear has priority over a simultaneous press; that press is consumed (dropped).
  - clear does not reset the debouncer, so a key held through clear generates no new event.
- range_err:
  - Computed from registered x and y using a 5-bit unsigned sum. It is registered, so it updates in the same cycle as operands_valid.
  - It is 0 outside SHOW.
  - Maximum sum is 30; there is no overflow beyond 5 bits.
- Outputs x/y are stable between press events, so the downstream adder sees no switch-induced changes.

Test Plan:
(All with DEBOUNCE_CYCLES=4.)
1. Reset, then sw=3 + press, then sw=5 + press -> x=3, y=5, state=10, operands_valid=1, new_pair pulses exactly one cycle, range_err=0.
2. key_n bounces low/high every 2 cycles for 20 cycles, then stays low 10 cycles -> exactly one load, at edge 6 after the stable low begins; state advances by one only.
3. sw=15 + press, sw=9 + press -> x=15, y=9, range_err=1. Then sw=4 + press -> state=01, x=4, y=9, operands_valid=0, range_err=0.
4. Hold key_n low 100 cycles, release, re-press -> exactly two events total. sw toggling during the hold does not change x/y.
5. clear asserted in the same cycle as press in LOAD_Y -> state=00, x=0, y=0, no transition to SHOW.
6. Assert reset during a debounce count (cycle 3 of 4) and mid-SHOW -> all outputs 0 immediately (asynchronously); no event after reset deasserts while the key is still held, until release and re-press.
